// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected side: default word formats
// and the flatten-buffer state type.
package fc_pkg;

    localparam int FC_WORD_SIZE      = 16;
    localparam int FC_INT_SLICE      = 8;
    localparam int FC_IP_LAYER1_SIZE = 128;
    localparam int FC_ACC_WIDTH      = 32;
    localparam int FC_IN_FRAC        = 16;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } flat_state_t;

endpackage

// File: rtl/fixed_point_narrow.sv
// Combinational narrowing of a wide signed accumulator word to the FC word
// format: round half up, arithmetic shift, saturate, optional ReLU.
module fixed_point_narrow
    import fc_pkg::*;
#(
    parameter int ACC_WIDTH = FC_ACC_WIDTH,
    parameter int IN_FRAC   = FC_IN_FRAC,
    parameter int WORD_SIZE = FC_WORD_SIZE,
    parameter int INT_SLICE = FC_INT_SLICE,
    parameter bit RELU_EN   = 1'b1
) (
    input  logic signed [ACC_WIDTH-1:0] i_data,
    output logic signed [WORD_SIZE-1:0] o_word
);

    // Number of fraction bits dropped on the way to the output format.
    localparam int SH = IN_FRAC - (WORD_SIZE - INT_SLICE);
    // One guard bit above the accumulator so the rounding add cannot wrap.
    localparam int SW = ACC_WIDTH + 1;

    localparam logic signed [SW-1:0] RND =
        (SH > 0) ? (SW'(1) << ((SH > 0) ? (SH - 1) : 0)) : '0;
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};

    logic signed [WORD_SIZE-1:0] w_sat;

    function automatic logic signed [SW-1:0] round_shift(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [SW-1:0] s;
        s = {v[ACC_WIDTH-1], v};
        s = s + RND;
        return s >>> SH;
    endfunction

    function automatic logic signed [WORD_SIZE-1:0] saturate(input logic signed [SW-1:0] s);
        if (s > SAT_MAX) begin
            return SAT_MAX[WORD_SIZE-1:0];
        end
        if (s < SAT_MIN) begin
            return SAT_MIN[WORD_SIZE-1:0];
        end
        return s[WORD_SIZE-1:0];
    endfunction

    // Round/saturate, then clamp negatives to zero when ReLU is enabled.
    always_comb begin
        w_sat  = saturate(round_shift(i_data));
        o_word = (RELU_EN && w_sat[WORD_SIZE-1]) ? '0 : w_sat;
    end

endmodule

// File: rtl/cnn_flatten_buffer.sv
// Collects converted CNN result beats into a flat vector for the FC stage
// and holds the completed vector until the FC side acknowledges it.
module cnn_flatten_buffer
    import fc_pkg::*;
#(
    parameter int WORD_SIZE      = FC_WORD_SIZE,
    parameter int INT_SLICE      = FC_INT_SLICE,
    parameter int IP_LAYER1_SIZE = FC_IP_LAYER1_SIZE,
    parameter int ACC_WIDTH      = FC_ACC_WIDTH,
    parameter int IN_FRAC        = FC_IN_FRAC,
    parameter bit RELU_EN        = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic signed [ACC_WIDTH-1:0]             in_data,
    input  logic                                    in_last,
    output logic signed [WORD_SIZE-1:0]             x_vec [IP_LAYER1_SIZE],
    output logic                                    cnn_done,
    input  logic                                    fc_ack,
    output logic                                    frame_err,
    output logic [$clog2(IP_LAYER1_SIZE+1)-1:0]     fill_count
);

    localparam int CNT_W = $clog2(IP_LAYER1_SIZE + 1);
    localparam int IDX_W = $clog2(IP_LAYER1_SIZE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IP_LAYER1_SIZE - 1);

    flat_state_t                 r_state;
    logic                        r_in_ready;
    logic                        r_cnn_done;
    logic                        r_frame_err;
    logic [CNT_W-1:0]            r_fill_count;
    logic signed [WORD_SIZE-1:0] r_x_vec [IP_LAYER1_SIZE];

    logic signed [WORD_SIZE-1:0] w_word;
    logic                        w_accept;
    logic                        w_last_slot;
    logic [IDX_W-1:0]            w_wr_idx;

    assign w_accept    = in_valid && r_in_ready && (r_state == FILL);
    assign w_last_slot = (r_fill_count == LAST_IDX);
    assign w_wr_idx    = r_fill_count[IDX_W-1:0];

    fixed_point_narrow #(
        .ACC_WIDTH (ACC_WIDTH),
        .IN_FRAC   (IN_FRAC),
        .WORD_SIZE (WORD_SIZE),
        .INT_SLICE (INT_SLICE),
        .RELU_EN   (RELU_EN)
    ) u_narrow (
        .i_data (in_data),
        .o_word (w_word)
    );

    // Vector storage: each accepted beat lands at the current fill slot;
    // entries are never cleared except by reset, so stale words persist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IP_LAYER1_SIZE; i++) begin
                r_x_vec[i] <= '0;
            end
        end else if (w_accept) begin
            r_x_vec[w_wr_idx] <= w_word;
        end
    end

    // Fill/hold FSM with fill counter, handshake flags and framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FILL;
            r_in_ready   <= 1'b0;
            r_cnn_done   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_fill_count <= '0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                FILL: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_last_slot) begin
                            // Vector is full: publish it whether or not last was flagged.
                            r_state      <= HOLD;
                            r_cnn_done   <= 1'b1;
                            r_in_ready   <= 1'b0;
                            r_fill_count <= r_fill_count + CNT_W'(1);
                            r_frame_err  <= !in_last;
                        end else if (in_last) begin
                            // Short frame: drop it and restart filling from slot 0.
                            r_fill_count <= '0;
                            r_frame_err  <= 1'b1;
                        end else begin
                            r_fill_count <= r_fill_count + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    r_in_ready <= 1'b0;
                    if (fc_ack) begin
                        r_state      <= FILL;
                        r_cnn_done   <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_fill_count <= '0;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign cnn_done   = r_cnn_done;
    assign frame_err  = r_frame_err;
    assign fill_count = r_fill_count;
    assign x_vec      = r_x_vec;

endmodule

// File: doc/cnn_flatten_buffer.md
# cnn_flatten_buffer

Sequential flatten/collect stage between the CNN feature-map output and the fully connected classifier. It takes the CNN's wide fixed-point results one beat at a time over a valid/ready stream and converts each beat to the FC word format with rounding, saturation and optional ReLU. It stores the converted words into a `IP_LAYER1_SIZE`-entry vector and presents the complete vector with `cnn_done` to the combinational FC stage. It holds the vector stable until the FC side acknowledges.

## Interface
- `WORD_SIZE`, 16, width of each output vector word (signed, Q(INT_SLICE).(WORD_SIZE-INT_SLICE)).
- `INT_SLICE`, 8, integer bits of the output format, sign included.
- `IP_LAYER1_SIZE`, 128, number of words per frame.
- `ACC_WIDTH`, 32, width of the incoming CNN accumulator word (signed).
- `IN_FRAC`, 16, fraction bits of the incoming word; must be ≥ WORD_SIZE-INT_SLICE.
- `RELU_EN`, 1, when 1 negative results are forced to 0.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: buffer accepts a beat this cycle.
- `in_data` in ACC_WIDTH: signed CNN result.
- `in_last` in 1: marks the final beat of a frame.
- `x_vec` out WORD_SIZE × IP_LAYER1_SIZE (unpacked): flattened vector; index 0 is the first beat.
- `cnn_done` out 1: level; the vector is complete and stable.
- `fc_ack` in 1: FC has consumed the vector; sampled only while `cnn_done`=1.
- `frame_err` out 1: one-cycle pulse on a framing error.
- `fill_count` out $clog2(IP_LAYER1_SIZE+1): words written in the current frame.

## Operation
- States: FILL and HOLD. Reset enters FILL.
- A beat is accepted on the rising edge where `in_valid`&&`in_ready`.
- Conversion, per beat:
  - Let SH = IN_FRAC-(WORD_SIZE-INT_SLICE).
  - If SH>0, add 2^(SH-1) to the value (round half up).
  - Arithmetic-shift right by SH.
  - Saturate to [-2^(WORD_SIZE-1), 2^(WORD_SIZE-1)-1].
  - If RELU_EN and the result is negative, output 0.
  - Intermediate sum is ACC_WIDTH+1 bits; no wrap.
- FILL:
  - `in_ready`=1.
  - Each accepted beat writes `x_vec[fill_count]` and increments `fill_count`.
- Normal completion: the beat accepted at `fill_count`=IP_LAYER1_SIZE-1 with `in_last`=1.
  - Go to HOLD; `cnn_done`←1; `in_ready`←0.
- Missing last: the same beat with `in_last`=0.
  - Go to HOLD and publish the vector.
  - Pulse `frame_err`.
  - Further upstream beats are treated as the next frame.
- Early last: `in_last`=1 at `fill_count`<IP_LAYER1_SIZE-1.
  - That word is written.
  - Pulse `frame_err`.
  - `fill_count`←0; stay in FILL; `cnn_done` is not asserted.
  - Stale entries are not cleared.
- HOLD:
  - `in_ready`=0; `x_vec` frozen; `cnn_done`=1.
  - `fc_ack`=1 → FILL next edge, with `fill_count`←0 and `cnn_done`←0.
  - `x_vec` keeps its old contents until overwritten.
- `fc_ack` is ignored in FILL.
- Reset asserted mid-frame or in HOLD: all state is cleared immediately (asynchronous).
  - The partial frame is discarded; no `frame_err` pulse.

## Timing
- Reset values:
  - `in_ready`=0, `cnn_done`=0, `frame_err`=0, `fill_count`=0.
  - All `x_vec` words = 0.
- `in_ready` rises on the first edge after `rst_n` deasserts.
- All outputs are registered.
- Write latency: the word is visible on `x_vec` the cycle after acceptance.
- Completion:
  - `cnn_done` and `in_ready`=0 take effect the cycle after the final beat.
  - No beat can be accepted while `cnn_done`=1.
- Minimum frame-to-frame period: IP_LAYER1_SIZE + 2 cycles (ack in the first HOLD cycle).
- `fc_ack` held high is sampled once.
  - The first HOLD cycle with `fc_ack`=1 releases the buffer.
  - The following FILL cycles ignore it.
- FC combinational settle time is the consumer's concern; `x_vec` is guaranteed stable from the first `cnn_done` cycle until one cycle after the acknowledged `fc_ack`.

## Structure
- Shared package `fc_pkg`:
  - WORD_SIZE, INT_SLICE, IP_LAYER1_SIZE, ACC_WIDTH, IN_FRAC defaults.
  - State enum `flat_state_t` {FILL, HOLD}.
  - Shared by FC-side blocks.
- One combinational sub-module `fixed_point_narrow` (round, saturate, ReLU), parameterised by ACC_WIDTH, IN_FRAC, WORD_SIZE, INT_SLICE, RELU_EN.
  - Reused later between FC layers.
- Top holds the FSM, counter, vector register and error pulse.

## Test plan
- Conversion (RELU_EN=0):
  - 0x0001_8000 → 0x0180.
  - 0x0000_0080 → 0x0001.
  - 0x0000_007F → 0x0000.
  - 0x7FFF_0000 → 0x7FFF.
  - 0x8000_0000 → 0x8000.
  - 0xFFFE_0000 → 0xFE00.
  - With RELU_EN=1, 0xFFFE_0000 → 0x0000.
- Full frame of 128 beats, word k = k<<16, last on beat 127:
  - `x_vec[k]`=k<<8.
  - `cnn_done`=1 the cycle after beat 127.
  - `in_ready`=0; no `frame_err`.
- Backpressure: hold `in_valid`=1 during HOLD for 10 cycles, then `fc_ack` pulse.
  - No beat accepted; `x_vec` unchanged.
  - `cnn_done` low and `in_ready` high one cycle after the ack.
- Early last on beat 50:
  - `frame_err` pulses once; `fill_count`→0.
  - `cnn_done` stays 0.
  - The next full frame completes normally.
- Missing last (no `in_last` by beat 127):
  - `frame_err` pulses together with the `cnn_done` rise.
  - After ack, the next beat lands at `x_vec[0]`.
- Async reset asserted at beat 60 and in HOLD:
  - All outputs return to reset values without waiting for a clock edge.
  - `in_ready`=1 first edge after release.
